// File: rtl/axi_burst_mst_pkg.sv
// Shared types and helpers for the single-outstanding AXI4 burst master.
package axi_burst_mst_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_REJECT,
    ST_TOUT,
    ST_HALT
  } mst_state_e;

  // Error code reported for locally generated failures (4KB reject, timeout).
  localparam logic [1:0] RESP_LOCAL = 2'b11;

  // True when a burst starting at page offset off would run past the 4KB page.
  function automatic logic crosses_4k(input logic [11:0] off,
                                      input logic [7:0]  len,
                                      input logic [2:0]  size);
    logic [16:0] bytes;
    bytes = (17'(len) + 17'd1) << size;
    return (17'(off) + bytes) > 17'd4096;
  endfunction

endpackage

// File: rtl/axi_burst_mst_if.sv
// AXI4 interconnect-side bundle (AW/W/B/AR/R) with master and slave views.
interface axi_burst_mst_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst, arid,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst, arid,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );

endinterface

// File: rtl/axi_burst_mst_wdog.sv
// Response watchdog: counts consecutive enabled cycles and trips on the
// TIMEOUT-th one. TIMEOUT = 0 disables tripping entirely.
module axi_wdog_ctr #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic trip_o
);
  localparam int             CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q;

  // Trip on the cycle that would bring the idle count up to TIMEOUT.
  assign trip_o = (TIMEOUT != 0) && en_i && (cnt_q == LIM);

  // Idle-cycle counter; cleared whenever the slave shows activity.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (TIMEOUT != 0) && (cnt_q != LIM)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/axi_burst_mst.sv
// Single-outstanding AXI4 master: turns core requests into INCR read/write
// bursts, rejects 4KB-crossing bursts locally and halts on a silent slave.
module axi_burst_mst
  import axi_burst_mst_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int ID_VAL  = 0,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 1023,
  localparam int STRB_W = DATA_W / 8,
  localparam int LEN_W  = $clog2(MAX_LEN)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic [2:0]        req_size_i,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [STRB_W-1:0] wb_strb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_last_o,
  output logic [1:0]        rsp_err_o,
  output logic              halted_o,
  axi_burst_mst_if.master   m
);

  localparam logic [ID_W-1:0] ID_C = ID_W'(ID_VAL);

  mst_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [7:0]        beat_q;

  logic              last_beat;
  logic              wd_en;
  logic              wd_clr;
  logic              wd_trip;

  assign last_beat = (beat_q == len_q);

  // Watchdog only runs while waiting on R or B and nothing is being offered.
  assign wd_en  = ((state_q == ST_RD_DATA) && !m.rvalid) ||
                  ((state_q == ST_WR_RESP) && !m.bvalid);
  assign wd_clr = !wd_en;

  axi_wdog_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (wd_clr),
    .en_i   (wd_en),
    .trip_o (wd_trip)
  );

  // Address channels carry the registered request for as long as valid is up.
  assign m.awvalid = (state_q == ST_WR_ADDR);
  assign m.awaddr  = addr_q;
  assign m.awlen   = len_q;
  assign m.awsize  = size_q;
  assign m.awburst = BURST_INCR;
  assign m.awid    = ID_C;
  assign m.arvalid = (state_q == ST_RD_ADDR);
  assign m.araddr  = addr_q;
  assign m.arlen   = len_q;
  assign m.arsize  = size_q;
  assign m.arburst = BURST_INCR;
  assign m.arid    = ID_C;

  // W is a straight pass-through of the core beat stream, gated by state.
  assign m.wvalid  = (state_q == ST_WR_DATA) && wb_valid_i;
  assign m.wdata   = wb_data_i;
  assign m.wstrb   = wb_strb_i;
  assign m.wlast   = last_beat;
  assign wb_ready_o = (state_q == ST_WR_DATA) && m.wready;

  assign req_ready_o = (state_q == ST_IDLE);
  assign halted_o    = (state_q == ST_HALT);

  // Response mux and R/B ready steering; HALT sinks everything the slave sends.
  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_data_o  = '0;
    rsp_last_o  = 1'b1;
    rsp_err_o   = RESP_OKAY;
    m.rready    = 1'b0;
    m.bready    = 1'b0;
    case (state_q)
      ST_RD_DATA: begin
        rsp_valid_o = m.rvalid;
        rsp_data_o  = m.rdata;
        rsp_last_o  = m.rlast;
        // A misplaced RLAST or a foreign ID means the burst cannot be trusted.
        rsp_err_o   = ((m.rlast != last_beat) || (m.rid != ID_C)) ? RESP_LOCAL : m.rresp;
        m.rready    = rsp_ready_i;
      end
      ST_WR_RESP: begin
        rsp_valid_o = m.bvalid;
        rsp_err_o   = (m.bid != ID_C) ? RESP_LOCAL : m.bresp;
        m.bready    = rsp_ready_i;
      end
      ST_REJECT, ST_TOUT: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = RESP_LOCAL;
      end
      ST_HALT: begin
        m.rready    = 1'b1;
        m.bready    = 1'b1;
      end
      default: ;
    endcase
  end

  // Transaction FSM with request capture and beat counting.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            addr_q <= req_addr_i;
            len_q  <= 8'(req_len_i);
            size_q <= req_size_i;
            beat_q <= '0;
            if (crosses_4k(req_addr_i[11:0], 8'(req_len_i), req_size_i)) begin
              state_q <= ST_REJECT;
            end else if (req_we_i) begin
              state_q <= ST_WR_ADDR;
            end else begin
              state_q <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (m.arready) state_q <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (wd_trip) begin
            state_q <= ST_TOUT;
          end else if (m.rvalid && rsp_ready_i) begin
            beat_q <= beat_q + 8'd1;
            if (m.rlast) state_q <= ST_IDLE;
          end
        end
        ST_WR_ADDR: begin
          if (m.awready) state_q <= ST_WR_DATA;
        end
        ST_WR_DATA: begin
          if (wb_valid_i && m.wready) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) state_q <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (wd_trip) begin
            state_q <= ST_TOUT;
          end else if (m.bvalid && rsp_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_REJECT: begin
          if (rsp_ready_i) state_q <= ST_IDLE;
        end
        ST_TOUT: begin
          if (rsp_ready_i) state_q <= ST_HALT;
        end
        ST_HALT: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mst.sv
// Directed bench for axi_burst_mst: request routing/4KB table plus read,
// write, backpressure, reset and watchdog sequences.
module tb_axi_burst_mst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [2:0]  req_size;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_data;
  logic [7:0]  wb_strb;
  logic        rsp_valid, rsp_ready, rsp_last, halted;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_err;

  int checks = 0;
  int errors = 0;

  axi_burst_mst_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus ();

  axi_burst_mst #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4), .ID_VAL(0), .MAX_LEN(16), .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_len_i(req_len), .req_size_i(req_size),
    .wb_valid_i(wb_valid), .wb_ready_o(wb_ready), .wb_data_i(wb_data), .wb_strb_i(wb_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_last_o(rsp_last), .rsp_err_o(rsp_err), .halted_o(halted),
    .m(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic        rej;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_we = 0; req_addr = '0; req_len = '0; req_size = '0;
    wb_valid = 0; wb_data = '0; wb_strb = '0; rsp_ready = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0; bus.bid = '0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.rid = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Presents a request at a negedge; returns just after the accepting posedge.
  task automatic send_req(input logic we, input logic [31:0] a, input logic [3:0] l,
                          input logic [2:0] s);
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_len = l; req_size = s;
    #1 chk("req_ready_at_issue", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  initial begin
    int n;
    idle_inputs();
    vecs[0] = '{1'b0, 32'h0000_1000, 4'd3,  3'd3, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0FF8, 4'd15, 3'd3, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_0FF8, 4'd0,  3'd3, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0FF8, 4'd1,  3'd3, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0F80, 4'd15, 3'd3, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_1FFC, 4'd0,  3'd2, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_1FFC, 4'd1,  3'd2, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0FFF, 4'd0,  3'd0, 1'b0};
    vecs[8] = '{1'b0, 32'h0000_2FFE, 4'd1,  3'd1, 1'b1};
    vecs[9] = '{1'b1, 32'h0000_0000, 4'd15, 3'd3, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_arvalid", bus.arvalid, 1'b0);
    chk("rst_awvalid", bus.awvalid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    @(negedge clk);
    rst_n = 1;

    // Routing and 4KB boundary table
    for (int i = 0; i < 10; i++) begin
      send_req(vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].size);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_arvalid", i), bus.arvalid, !vecs[i].rej && !vecs[i].we);
      chk($sformatf("v%0d_awvalid", i), bus.awvalid, !vecs[i].rej && vecs[i].we);
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].rej);
      chk($sformatf("v%0d_wb_ready", i), wb_ready, 1'b0);
      if (vecs[i].rej) begin
        chk($sformatf("v%0d_rej_err", i), rsp_err, 2'b11);
        chk($sformatf("v%0d_rej_last", i), rsp_last, 1'b1);
        rsp_ready = 1;
        @(negedge clk);
        #1 chk($sformatf("v%0d_rej_idle", i), req_ready, 1'b1);
      end
      apply_reset();
    end

    // Read burst len=3 size=3 with AR stall and a 5-cycle rsp_ready stall
    send_req(1'b0, 32'h0000_1000, 4'd3, 3'd3);
    @(negedge clk);
    #1;
    chk("rd_arvalid", bus.arvalid, 1'b1);
    chk("rd_araddr", bus.araddr, 32'h1000);
    chk("rd_arlen", bus.arlen, 8'd3);
    chk("rd_arsize", bus.arsize, 3'd3);
    chk("rd_arburst", bus.arburst, 2'b01);
    chk("rd_arid", bus.arid, 4'd0);
    chk("rd_req_ready", req_ready, 1'b0);
    @(negedge clk);
    #1 chk("rd_ar_hold", bus.arvalid, 1'b1);
    bus.arready = 1;
    @(posedge clk);
    #1 bus.arready = 0;
    rsp_ready = 1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.rvalid = 1; bus.rdata = 64'hA000 + 64'(b); bus.rlast = (b == 3); bus.rresp = 2'b00;
      if (b == 1) begin
        rsp_ready = 0;
        for (int s = 0; s < 5; s++) begin
          #1;
          chk("rd_stall_rready", bus.rready, 1'b0);
          chk("rd_stall_data", rsp_data, 64'hA001);
          @(negedge clk);
        end
        rsp_ready = 1;
      end
      #1;
      chk($sformatf("rd_b%0d_valid", b), rsp_valid, 1'b1);
      chk($sformatf("rd_b%0d_data", b), rsp_data, 64'hA000 + 64'(b));
      chk($sformatf("rd_b%0d_last", b), rsp_last, b == 3);
      chk($sformatf("rd_b%0d_err", b), rsp_err, 2'b00);
      chk($sformatf("rd_b%0d_rready", b), bus.rready, 1'b1);
      @(posedge clk);
      #1 bus.rvalid = 0;
    end
    @(negedge clk);
    #1;
    chk("rd_done_idle", req_ready, 1'b1);
    chk("rd_done_rsp_valid", rsp_valid, 1'b0);

    // Single-beat write, AW stalled two cycles, slave answers SLVERR
    idle_inputs();
    send_req(1'b1, 32'h0000_0020, 4'd0, 3'd3);
    bus.wready = 1; wb_valid = 1; wb_data = 64'h1122_3344_5566_7788; wb_strb = 8'h0F;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      #1;
      chk("wr_aw_hold", bus.awvalid, 1'b1);
      chk("wr_awaddr", bus.awaddr, 32'h20);
      chk("wr_awlen", bus.awlen, 8'd0);
      chk("wr_no_w_early", bus.wvalid, 1'b0);
      chk("wr_no_wb_early", wb_ready, 1'b0);
    end
    bus.awready = 1;
    @(posedge clk);
    #1 bus.awready = 0;
    @(negedge clk);
    #1;
    chk("wr_wvalid", bus.wvalid, 1'b1);
    chk("wr_wlast", bus.wlast, 1'b1);
    chk("wr_wstrb", bus.wstrb, 8'h0F);
    chk("wr_wdata", bus.wdata, 64'h1122_3344_5566_7788);
    chk("wr_wb_ready", wb_ready, 1'b1);
    chk("wr_aw_dropped", bus.awvalid, 1'b0);
    @(posedge clk);
    #1 wb_valid = 0;
    @(negedge clk);
    bus.bvalid = 1; bus.bresp = 2'b10; rsp_ready = 1;
    #1;
    chk("wr_w_done", bus.wvalid, 1'b0);
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_err", rsp_err, 2'b10);
    chk("wr_rsp_data", rsp_data, 64'h0);
    chk("wr_rsp_last", rsp_last, 1'b1);
    chk("wr_bready", bus.bready, 1'b1);
    @(posedge clk);
    #1 bus.bvalid = 0;
    @(negedge clk);
    #1 chk("wr_done_idle", req_ready, 1'b1);

    // RLAST arriving early on a 2-beat read
    idle_inputs();
    send_req(1'b0, 32'h0000_0300, 4'd1, 3'd3);
    bus.arready = 1;
    @(posedge clk);
    #1 bus.arready = 0;
    @(negedge clk);
    bus.rvalid = 1; bus.rdata = 64'h55; bus.rlast = 1; rsp_ready = 1;
    #1;
    chk("rlast_mis_err", rsp_err, 2'b11);
    chk("rlast_mis_last", rsp_last, 1'b1);
    @(posedge clk);
    #1 bus.rvalid = 0;
    @(negedge clk);
    #1 chk("rlast_mis_idle", req_ready, 1'b1);

    // Reset asserted while beat 2 of a 4-beat write is on the bus
    idle_inputs();
    send_req(1'b1, 32'h0000_0100, 4'd3, 3'd3);
    bus.awready = 1;
    @(posedge clk);
    #1 bus.awready = 0;
    bus.wready = 1; wb_valid = 1; wb_strb = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk("rst_mid_wvalid_pre", bus.wvalid, 1'b1);
    rst_n = 0;
    #1;
    chk("rst_mid_wvalid", bus.wvalid, 1'b0);
    chk("rst_mid_awvalid", bus.awvalid, 1'b0);
    chk("rst_mid_wb_ready", wb_ready, 1'b0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    send_req(1'b0, 32'h0000_0200, 4'd0, 3'd3);
    @(negedge clk);
    #1;
    chk("post_rst_arvalid", bus.arvalid, 1'b1);
    chk("post_rst_araddr", bus.araddr, 32'h200);
    chk("post_rst_awvalid", bus.awvalid, 1'b0);
    apply_reset();

    // Silent slave: watchdog trips after 8 idle cycles, then HALT
    send_req(1'b0, 32'h0000_0040, 4'd0, 3'd3);
    bus.arready = 1;
    @(posedge clk);
    #1 bus.arready = 0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rsp_valid) break;
    end
    #1;
    chk("tout_cycles", 64'(n), 64'd8);
    chk("tout_err", rsp_err, 2'b11);
    chk("tout_last", rsp_last, 1'b1);
    chk("tout_req_ready", req_ready, 1'b0);
    rsp_ready = 1;
    @(negedge clk);
    #1;
    chk("halt_halted", halted, 1'b1);
    chk("halt_rsp_valid", rsp_valid, 1'b0);
    chk("halt_rready", bus.rready, 1'b1);
    chk("halt_bready", bus.bready, 1'b1);
    req_valid = 1; req_we = 0; req_addr = 32'h80;
    for (int s = 0; s < 3; s++) begin
      #1 chk("halt_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    #1;
    chk("halt_no_ar", bus.arvalid, 1'b0);
    chk("halt_sticky", halted, 1'b1);
    req_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
